ifmap_pp_sched: RTL and testbench

- Tile scheduler for the ping-pong ifmap/result buffer pair.
- Decides when the two banks swap roles (one `conv_en` pulse per swap), starts the compute engine, and tells the buffer when result data may be drained to DMA (`w_done` pulse).
- Counts tiles for one layer and reports layer completion.
- Sits between the AXI-lite register block, the DMA loader, the GEMM engine and the buffer.

---
 rtl/ifmap_pp_sched.sv | 146 ++++++++++++++
 tb/tb_ifmap_pp_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_pp_sched.sv
// ifmap_pp_sched: tile scheduler for the ping-pong ifmap/result buffer pair.
// Sequences load -> bank swap -> compute -> drain per tile and counts tiles per layer.
module ifmap_pp_sched #(
    parameter int TILE_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              start,
    input  logic              abort,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              load_done,
    input  logic              comp_done,
    input  logic              drain_done,
    output logic              load_ready,
    output logic              conv_en,
    output logic              comp_start,
    output logic              w_done,
    output logic              bank_sel,
    output logic              busy,
    output logic              layer_done,
    output logic              err,
    output logic [TILE_W-1:0] tiles_done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [TILE_W-1:0] num_q, num_d, load_cnt_q, load_cnt_d, swap_cnt_q, swap_cnt_d, tiles_q, tiles_d;
    logic              loaded_q, loaded_d, computing_q, computing_d, draining_q, draining_d;
    logic              cs_q, cs_d, wd_q, wd_d, bank_q, bank_d, err_q, err_d;
    logic              pl_q, pl_d, pc_q, pc_d, pd_q, pd_d;
    logic              run, ld_ev, cd_ev, dd_ev, ld_ok, cd_ok, dd_ok;

    // Events seen while disabled are held in pl/pc/pd and replayed on the first enabled cycle.
    assign run   = enable && (state_q == RUN);
    assign ld_ev = enable && (load_done || pl_q);
    assign cd_ev = enable && (comp_done || pc_q);
    assign dd_ev = enable && (drain_done || pd_q);

    // A pending w_done also blocks the swap so the bank cannot flip before its drain has started.
    assign load_ready = run && !loaded_q && (load_cnt_q < num_q);
    assign conv_en    = run && loaded_q && !computing_q && !draining_q && !cs_q && !wd_q
                        && (swap_cnt_q < num_q);
    assign comp_start = run && cs_q;
    assign w_done     = run && wd_q;
    assign ld_ok      = ld_ev && load_ready;
    assign cd_ok      = cd_ev && computing_q;
    assign dd_ok      = dd_ev && draining_q;
    assign bank_sel   = bank_q;
    assign busy       = (state_q != IDLE);
    assign layer_done = enable && (state_q == DONE);
    assign err        = err_q;
    assign tiles_done = tiles_q;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        load_cnt_d  = ld_ok ? load_cnt_q + TILE_W'(1) : load_cnt_q;
        swap_cnt_d  = conv_en ? swap_cnt_q + TILE_W'(1) : swap_cnt_q;
        tiles_d     = dd_ok ? tiles_q + TILE_W'(1) : tiles_q;
        bank_d      = bank_q ^ conv_en;
        loaded_d    = ld_ok || (loaded_q && !conv_en);
        computing_d = comp_start || (computing_q && !cd_ok);
        draining_d  = w_done || (draining_q && !dd_ok);
        cs_d        = enable ? conv_en : cs_q;
        wd_d        = enable ? cd_ok : wd_q;
        pl_d        = !enable && (pl_q || load_done);
        pc_d        = !enable && (pc_q || comp_done);
        pd_d        = !enable && (pd_q || drain_done);
        err_d       = err_q || (ld_ev && !load_ready) || (cd_ev && !computing_q)
                      || (dd_ev && !draining_q);
        if (dd_ok && tiles_d == num_q)
            state_d = DONE;
        if (enable && state_q == DONE)
            state_d = IDLE;
        if (enable && start) begin
            if (state_q == IDLE) begin
                num_d       = num_tiles;
                load_cnt_d  = '0;
                swap_cnt_d  = '0;
                tiles_d     = '0;
                loaded_d    = 1'b0;
                computing_d = 1'b0;
                draining_d  = 1'b0;
                cs_d        = 1'b0;
                wd_d        = 1'b0;
                err_d       = (num_tiles == '0);
                state_d     = (num_tiles == '0) ? IDLE : RUN;
            end else begin
                err_d = 1'b1;
            end
        end
        if (abort) begin
            state_d     = IDLE;
            num_d       = '0;
            load_cnt_d  = '0;
            swap_cnt_d  = '0;
            tiles_d     = '0;
            loaded_d    = 1'b0;
            computing_d = 1'b0;
            draining_d  = 1'b0;
            cs_d        = 1'b0;
            wd_d        = 1'b0;
            pl_d        = 1'b0;
            pc_d        = 1'b0;
            pd_d        = 1'b0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            num_q       <= '0;
            load_cnt_q  <= '0;
            swap_cnt_q  <= '0;
            tiles_q     <= '0;
            loaded_q    <= 1'b0;
            computing_q <= 1'b0;
            draining_q  <= 1'b0;
            cs_q        <= 1'b0;
            wd_q        <= 1'b0;
            bank_q      <= 1'b0;
            err_q       <= 1'b0;
            pl_q        <= 1'b0;
            pc_q        <= 1'b0;
            pd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            load_cnt_q  <= load_cnt_d;
            swap_cnt_q  <= swap_cnt_d;
            tiles_q     <= tiles_d;
            loaded_q    <= loaded_d;
            computing_q <= computing_d;
            draining_q  <= draining_d;
            cs_q        <= cs_d;
            wd_q        <= wd_d;
            bank_q      <= bank_d;
            err_q       <= err_d;
            pl_q        <= pl_d;
            pc_q        <= pc_d;
            pd_q        <= pd_d;
        end
    end
endmodule

// File: tb/tb_ifmap_pp_sched.sv
// tb_ifmap_pp_sched: directed bench for the ping-pong tile scheduler.
module tb_ifmap_pp_sched;
    localparam int W = 16;

    logic         clk = 1'b0, rstn = 1'b0, enable = 1'b1, start = 1'b0, abort = 1'b0;
    logic [W-1:0] num_tiles = '0;
    logic         a_load = 1'b0, a_comp = 1'b0, a_drain = 1'b0;
    logic         m_load = 1'b0, m_comp = 1'b0, m_drain = 1'b0;
    logic         load_done, comp_done, drain_done;
    logic         load_ready, conv_en, comp_start, w_done, bank_sel, busy, layer_done, err;
    logic [W-1:0] tiles_done;

    int   n_cmp = 0, n_bad = 0;
    bit   auto_on = 1'b0;
    int   lt = 0, ct = 0, dt = 0;
    int   cyc = 0, n_conv = 0, n_wd = 0, n_ld = 0, cs_bad = 0;
    logic prev_conv = 1'b0;
    logic [7:0] bank_hist = '0;
    int   c0, w0, l0;

    assign load_done  = a_load | m_load;
    assign comp_done  = a_comp | m_comp;
    assign drain_done = a_drain | m_drain;

    always #5 clk = ~clk;

    ifmap_pp_sched #(.TILE_W(W)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .start(start), .abort(abort),
        .num_tiles(num_tiles), .load_done(load_done), .comp_done(comp_done),
        .drain_done(drain_done), .load_ready(load_ready), .conv_en(conv_en),
        .comp_start(comp_start), .w_done(w_done), .bank_sel(bank_sel), .busy(busy),
        .layer_done(layer_done), .err(err), .tiles_done(tiles_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int k);
        if (k == 0) m_load = 1'b1;
        if (k == 1) m_comp = 1'b1;
        if (k == 2) m_drain = 1'b1;
        step;
        m_load  = 1'b0;
        m_comp  = 1'b0;
        m_drain = 1'b0;
    endtask

    task automatic start_layer(input int n);
        num_tiles = W'(n);
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    // Monitor: pulse counts, bank value after each swap, comp_start must trail conv_en by one cycle.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (prev_conv) bank_hist = {bank_hist[6:0], bank_sel};
        if (comp_start !== prev_conv) cs_bad++;
        if (conv_en) n_conv++;
        if (w_done) n_wd++;
        if (layer_done) n_ld++;
        prev_conv = conv_en;
    end

    // Auto responder: each event answers 5 cycles after the pulse/level that enables it.
    initial forever begin
        @(negedge clk);
        if (auto_on) begin
            if (lt == 0 && load_ready && !a_load) lt = 5;
            if (ct == 0 && comp_start) ct = 5;
            if (dt == 0 && w_done) dt = 5;
        end
        @(posedge clk);
        #1;
        a_load  = (lt == 1);
        a_comp  = (ct == 1);
        a_drain = (dt == 1);
        if (lt > 0) lt--;
        if (ct > 0) ct--;
        if (dt > 0) dt--;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step;
        check("rst_load_ready", load_ready, 0);
        check("rst_conv_en", conv_en, 0);
        check("rst_comp_start", comp_start, 0);
        check("rst_w_done", w_done, 0);
        check("rst_busy", busy, 0);
        check("rst_bank", bank_sel, 0);
        check("rst_err", err, 0);
        check("rst_tiles", tiles_done, 0);
        check("rst_layer_done", layer_done, 0);
        rstn = 1'b1;
        step;

        // Three tiles, automatic responses
        auto_on = 1'b1;
        c0 = n_conv; w0 = n_wd; l0 = n_ld;
        start_layer(3);
        for (int i = 0; i < 400 && n_ld == l0; i++) step;
        auto_on = 1'b0;
        repeat (3) step;
        check("s1_conv_cnt", n_conv - c0, 3);
        check("s1_wdone_cnt", n_wd - w0, 3);
        check("s1_layer_done_once", n_ld - l0, 1);
        check("s1_bank_seq", bank_hist[2:0], 3'b101);
        check("s1_tiles", tiles_done, 3);
        check("s1_err", err, 0);
        check("s1_busy", busy, 0);

        // Zero tiles
        c0 = n_conv;
        start_layer(0);
        check("s3_err", err, 1);
        check("s3_busy", busy, 0);
        repeat (3) step;
        check("s3_no_conv", n_conv - c0, 0);

        // Second load waits behind compute and drain
        c0 = n_conv;
        start_layer(2);
        check("s2_err_cleared", err, 0);
        check("s2_busy", busy, 1);
        check("s2_load_ready", load_ready, 1);
        pulse(0);
        check("s2_conv1", conv_en, 1);
        step;
        check("s2_cs1", comp_start, 1);
        step;
        check("s2_lr2", load_ready, 1);
        pulse(0);
        repeat (4) step;
        check("s2_hold_compute", n_conv - c0, 1);
        pulse(1);
        check("s2_wdone1", w_done, 1);
        repeat (3) step;
        check("s2_hold_drain", n_conv - c0, 1);
        check("s2_no_conv_pre", conv_en, 0);
        pulse(2);
        check("s2_swap_after_drain", conv_en, 1);
        check("s2_tiles1", tiles_done, 1);
        step;
        check("s2_cs2", comp_start, 1);
        step;
        pulse(1);
        step;
        pulse(2);
        check("s2_layer_done", layer_done, 1);
        step;
        check("s2_busy_end", busy, 0);
        check("s2_tiles", tiles_done, 2);
        check("s2_err_end", err, 0);

        // Freeze while comp_done arrives
        w0 = n_wd;
        start_layer(1);
        pulse(0);
        check("s5_conv", conv_en, 1);
        step;
        check("s5_cs", comp_start, 1);
        step;
        enable = 1'b0;
        repeat (2) step;
        check("s5_frozen_lr", load_ready, 0);
        pulse(1);
        repeat (7) step;
        check("s5_no_wdone_frozen", n_wd - w0, 0);
        check("s5_no_err", err, 0);
        enable = 1'b1;
        check("s5_wdone_not_yet", w_done, 0);
        step;
        check("s5_wdone_after_enable", w_done, 1);
        step;
        pulse(2);
        check("s5_layer_done", layer_done, 1);
        step;
        check("s5_tiles", tiles_done, 1);
        check("s5_busy_end", busy, 0);

        // Load while load_ready low, then abort
        start_layer(2);
        pulse(0);
        check("s4_lr_low", load_ready, 0);
        check("s4_conv", conv_en, 1);
        pulse(0);
        check("s4_err", err, 1);
        check("s4_cnt_kept", load_ready, 1);
        check("s4_cs", comp_start, 1);
        step;
        abort = 1'b1;
        step;
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_err_cleared", err, 0);
        check("ab_bank_kept", bank_sel, 1);
        check("ab_tiles", tiles_done, 0);
        check("ab_lr", load_ready, 0);

        // Reset mid-layer
        start_layer(2);
        check("s6_busy", busy, 1);
        rstn = 1'b0;
        step;
        rstn = 1'b1;
        check("s6_busy", busy, 0);
        check("s6_bank", bank_sel, 0);
        check("s6_tiles", tiles_done, 0);
        check("s6_err", err, 0);
        check("s6_lr", load_ready, 0);
        check("cs_follows_conv", cs_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
